// File: rtl/ex_flag_if.sv
// EX->MEM boundary bus: EX-side inputs, branch query, and registered MEM/flag outputs.
interface ex_flag_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
);
  logic              ex_valid;
  logic [3:0]        ex_opcode;
  logic [DATA_W-1:0] ex_result;
  logic [REG_AW-1:0] ex_dst;
  logic              ex_wr_en;
  logic              alu_z;
  logic              alu_v;
  logic              alu_n;
  logic              stall;
  logic              flush;
  logic [2:0]        br_cond;
  logic              cond_true;
  logic              mem_valid;
  logic [3:0]        mem_opcode;
  logic [DATA_W-1:0] mem_result;
  logic [REG_AW-1:0] mem_dst;
  logic              mem_wr_en;
  logic              flag_z;
  logic              flag_v;
  logic              flag_n;

  modport master (
    output ex_valid, ex_opcode, ex_result, ex_dst, ex_wr_en,
    output alu_z, alu_v, alu_n, stall, flush, br_cond,
    input  cond_true, mem_valid, mem_opcode, mem_result, mem_dst, mem_wr_en,
    input  flag_z, flag_v, flag_n
  );

  modport slave (
    input  ex_valid, ex_opcode, ex_result, ex_dst, ex_wr_en,
    input  alu_z, alu_v, alu_n, stall, flush, br_cond,
    output cond_true, mem_valid, mem_opcode, mem_result, mem_dst, mem_wr_en,
    output flag_z, flag_v, flag_n
  );
endinterface

// File: rtl/ex_flag_stage.sv
// EX/MEM pipeline register with the architectural Z/V/N flag register and
// branch-condition resolution (optionally bypassing the committing instruction's flags).
module ex_flag_stage #(
  parameter int DATA_W       = 16,
  parameter int REG_AW       = 4,
  parameter int FLAG_BYPASS  = 1,
  parameter int R0_HARDWIRED = 1
) (
  input logic     clk,
  input logic     rst,
  ex_flag_if.slave bus
);
  typedef struct packed {
    logic              valid;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] result;
    logic [REG_AW-1:0] dst;
    logic              wr_en;
  } mem_t;

  mem_t mem_q, mem_d;
  logic flag_z_q, flag_v_q, flag_n_q;
  logic commit, ld_all, ld_z, r0_kill;
  logic z_nxt, v_nxt, n_nxt;
  logic fz, fv, fn;

  // ADD/SUB (0,1) update all flags; logic/shift ops (2..6) update Z only.
  always_comb begin
    commit  = bus.ex_valid & ~bus.stall & ~bus.flush;
    ld_all  = commit & (bus.ex_opcode <= 4'd1);
    ld_z    = commit & (bus.ex_opcode <= 4'd6);
    z_nxt   = ld_z   ? bus.alu_z : flag_z_q;
    v_nxt   = ld_all ? bus.alu_v : flag_v_q;
    n_nxt   = ld_all ? bus.alu_n : flag_n_q;
    r0_kill = (R0_HARDWIRED != 0) && (bus.ex_dst == '0);
  end

  // Next-state flags equal the registered ones when nothing commits,
  // so the bypass select needs no commit qualifier.
  always_comb begin
    fz = (FLAG_BYPASS != 0) ? z_nxt : flag_z_q;
    fv = (FLAG_BYPASS != 0) ? v_nxt : flag_v_q;
    fn = (FLAG_BYPASS != 0) ? n_nxt : flag_n_q;
    case (bus.br_cond)
      3'b000:  bus.cond_true = ~fz;
      3'b001:  bus.cond_true = fz;
      3'b010:  bus.cond_true = ~fz & ~fn;
      3'b011:  bus.cond_true = fn;
      3'b100:  bus.cond_true = fz | (~fz & ~fn);
      3'b101:  bus.cond_true = fn | fz;
      3'b110:  bus.cond_true = fv;
      default: bus.cond_true = 1'b1;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (bus.flush) begin
      mem_d = '0;
    end else if (!bus.stall) begin
      mem_d.valid  = bus.ex_valid;
      mem_d.opcode = bus.ex_opcode;
      mem_d.result = bus.ex_result;
      mem_d.dst    = bus.ex_dst;
      mem_d.wr_en  = bus.ex_valid & bus.ex_wr_en & ~r0_kill;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      flag_z_q <= 1'b0;
      flag_v_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      flag_z_q <= z_nxt;
      flag_v_q <= v_nxt;
      flag_n_q <= n_nxt;
    end
  end

  assign bus.mem_valid  = mem_q.valid;
  assign bus.mem_opcode = mem_q.opcode;
  assign bus.mem_result = mem_q.result;
  assign bus.mem_dst    = mem_q.dst;
  assign bus.mem_wr_en  = mem_q.wr_en;
  assign bus.flag_z     = flag_z_q;
  assign bus.flag_v     = flag_v_q;
  assign bus.flag_n     = flag_n_q;
endmodule

// File: doc/ex_flag_stage.md
Name: ex_flag_stage

Overview:
- EX/MEM boundary stage directly downstream of the 16-bit ALU. Registers the ALU result and its write-back control into the MEM stage.
- Owns the architectural Z/V/N flag register. Updates flags per opcode class when an instruction commits.
- Resolves the 3-bit branch condition against the flags, with optional same-cycle bypass.
- Supports pipeline stall and flush. Flush takes priority over stall.

Parameters:
- DATA_W, 16, width of the result path
- REG_AW, 4, register-index width
- FLAG_BYPASS, 1, when 1 the branch condition sees flags being written this cycle; when 0 it sees only the registered flags
- R0_HARDWIRED, 1, when 1 a write to register 0 is suppressed (mem_wr_en forced 0)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  EX holds a real instruction
- ex_opcode  in  4  instruction opcode
- ex_result  in  DATA_W  ALU output
- ex_dst  in  REG_AW  destination register
- ex_wr_en  in  1  instruction writes a register
- alu_z  in  1  ALU zero flag
- alu_v  in  1  ALU overflow flag
- alu_n  in  1  ALU negative flag
- stall  in  1  hold this stage
- flush  in  1  kill the EX instruction and insert a bubble
- br_cond  in  3  condition code to evaluate
- cond_true  out  1  br_cond satisfied (combinational)
- mem_valid  out  1  registered valid
- mem_opcode  out  4  registered opcode
- mem_result  out  DATA_W  registered result
- mem_dst  out  REG_AW  registered destination
- mem_wr_en  out  1  registered write enable
- flag_z  out  1  architectural Z
- flag_v  out  1  architectural V
- flag_n  out  1  architectural N

Behaviour:
- Reset (async, rst=1): every registered output and every flag = 0. Effect is immediate, not clock-gated. Reset mid-stall or mid-flush wins over both.
- commit = ex_valid & ~stall & ~flush.
- Pipeline register, evaluated at each rising edge in priority order:
  - flush=1: mem_valid, mem_wr_en, mem_opcode, mem_result and mem_dst all load 0. This applies regardless of stall.
  - else stall=1: all mem_* registers hold.
  - else: mem_* load the ex_* values. mem_valid <= ex_valid. mem_wr_en <= ex_valid & ex_wr_en & ~(R0_HARDWIRED & ex_dst==0).
- Latency: exactly 1 cycle from EX inputs to mem_* outputs.
- Flag update mask, applied only on commit:
  - 0000 ADD, 0001 SUB: Z, V, N all load from alu_z/alu_v/alu_n.
  - 0010 XOR, 0011 RED, 0100 SLL, 0101 SRA, 0110 ROR: only Z loads; V and N hold.
  - 0111 PADDSB and 1000–1111 (memory/control ops): no flag changes.
- A non-commit cycle never changes the flags. This covers invalid, stalled and flushed instructions.
- Effective flags (fz, fv, fn):
  - FLAG_BYPASS=1 and commit=1: the registered flags merged with the masked ALU flags, i.e. the next-state values.
  - Otherwise: the registered flags.
- cond_true, combinational from br_cond and the effective flags:
  - 000: ~fz
  - 001: fz
  - 010: ~fz & ~fn
  - 011: fn
  - 100: fz | (~fz & ~fn)
  - 101: fn | fz
  - 110: fv
  - 111: 1
- Simultaneous stall & flush: behaves as a flush, and the flags do not update.
- Back-to-back flag writers: the second sees the first's flags through the register. The bypass covers only the instruction currently in EX.

Test Plan:
- Reset: pulse rst mid-cycle with mem_* non-zero -> all outputs 0 immediately, without a clock edge. With br_cond=111 -> cond_true=1. With br_cond=000 -> cond_true=1 (Z=0).
- ADD then XOR: ADD with ex_result=0x7FFF, alu_v=1, alu_n=0, alu_z=0, ex_dst=3, ex_wr_en=1 -> next cycle mem_result=0x7FFF, mem_wr_en=1, flags Z0 V1 N0. Then XOR with alu_z=1, alu_n=1, alu_v=0 -> flags Z1 V1 N0, and br_cond=110 gives cond_true=1.
- Stall hold: SUB with alu_z=1 while stall=1 for 3 cycles -> mem_* unchanged and flags unchanged. Release stall -> flags Z1 and the mem_* values load 1 cycle later.
- Flush priority: stall=1, flush=1, ex_valid=1, ADD with alu_n=1 -> next cycle mem_valid=0, mem_wr_en=0, mem_result=0, flag_n unchanged.
- Bypass: FLAG_BYPASS=1, registered Z=0, committing SUB with alu_z=1, br_cond=001 -> cond_true=1 in the same cycle. With FLAG_BYPASS=0 under the same stimulus -> cond_true=0 that cycle and 1 the next.
- R0 suppression: ADD with ex_dst=0, ex_wr_en=1, ex_valid=1 -> mem_wr_en=0 and mem_valid=1. The flags still update.
